// File: rtl/pattern_count_engine.sv
// Pattern count engine: on a req pulse it reads a 5-bit pattern and a byte string from
// data memory, counts pattern occurrences three ways and writes the counts back.
module pattern_count_engine #(
  parameter int unsigned MSG_BASE = 0,
  parameter int unsigned NBYTES   = 32,
  parameter int unsigned PAT_ADDR = 32,
  parameter int unsigned OUT_ADDR = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  output logic       done,
  output logic       busy,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rdata,
  output logic       mem_we,
  output logic [7:0] mem_wdata
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [2:0] {
    IDLE, LOADPAT, SCAN, WR0, WR1, WR2, DONE
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      pat_q;
  logic [7:0]      prev_q;
  logic [IW-1:0]   idx_q;
  logic [7:0]      ctb_q, cto_q, cts_q;
  logic [2:0]      in_cnt, x_cnt;
  logic [15:0]     win;
  logic            last_byte;

  assign win       = {prev_q, mem_rdata};
  assign last_byte = (idx_q == IW'(NBYTES - 1));

  // Window matches for the byte on mem_rdata; crossing windows only exist once a previous byte has been seen.
  always_comb begin
    in_cnt = '0;
    x_cnt  = '0;
    for (int k = 0; k < 4; k++) begin
      if (mem_rdata[7-k -: 5] == pat_q) in_cnt = in_cnt + 3'd1;
      if ((idx_q != '0) && (win[11-k -: 5] == pat_q)) x_cnt = x_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    unique case (state_q)
      IDLE, DONE: begin
        done = (state_q == DONE);
        if (req) state_d = LOADPAT;
      end
      LOADPAT: begin
        busy    = 1'b1;
        state_d = SCAN;
      end
      SCAN: begin
        busy = 1'b1;
        if (last_byte) state_d = WR0;
      end
      WR0: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = ctb_q;
        state_d   = WR1;
      end
      WR1: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = cto_q;
        state_d   = WR2;
      end
      WR2: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = cts_q;
        state_d   = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr <= '0;
      pat_q    <= '0;
      prev_q   <= '0;
      idx_q    <= '0;
      ctb_q    <= '0;
      cto_q    <= '0;
      cts_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (req) begin
            mem_addr <= 8'(PAT_ADDR);
            prev_q   <= '0;
            idx_q    <= '0;
            ctb_q    <= '0;
            cto_q    <= '0;
            cts_q    <= '0;
          end
        end
        LOADPAT: begin
          pat_q    <= mem_rdata[7:3];
          mem_addr <= 8'(MSG_BASE);
          idx_q    <= '0;
        end
        SCAN: begin
          ctb_q    <= ctb_q + 8'(in_cnt);
          cto_q    <= cto_q + 8'(in_cnt != '0);
          cts_q    <= cts_q + 8'(in_cnt) + 8'(x_cnt);
          prev_q   <= mem_rdata;
          idx_q    <= idx_q + 1'b1;
          mem_addr <= last_byte ? 8'(OUT_ADDR) : mem_addr + 8'd1;
        end
        WR0:     mem_addr <= 8'(OUT_ADDR + 1);
        WR1:     mem_addr <= 8'(OUT_ADDR + 2);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_count_engine.sv
// Bench for pattern_count_engine: behavioural memory, a bit-string reference model,
// directed scenarios plus randomized pattern/message pairs.
module tb_pattern_count_engine;

  localparam int PAT = 32;
  localparam int OUT = 33;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic       done, busy, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0] mem [256];

  int n_pass = 0;
  int n_fail = 0;
  int n_checks = 0;
  int wr_count = 0;

  pattern_count_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata)
  );

  assign mem_rdata = mem[mem_addr];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Capture the write port before the edge, commit it after the edge.
  task automatic tick;
    logic       we;
    logic [7:0] a, d;
    @(negedge clk);
    we = mem_we; a = mem_addr; d = mem_wdata;
    @(posedge clk);
    #1;
    if (we && rst_n) begin
      mem[a] = d;
      wr_count++;
    end
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 32; i++) mem[i] = v;
  endtask

  // Reference: slide a 5-bit window over the 256-bit string, MSB of byte 0 first.
  task automatic model(output logic [7:0] ctb, output logic [7:0] cto, output logic [7:0] cts);
    logic [255:0] s;
    logic [31:0]  hit;
    logic [4:0]   p;
    int           a, b, c;
    p = mem[PAT][7:3];
    for (int i = 0; i < 32; i++) s[255-8*i -: 8] = mem[i];
    hit = '0; a = 0; c = 0;
    for (int k = 0; k <= 251; k++) begin
      if (s[255-k -: 5] == p) begin
        c++;
        if ((k % 8) <= 3) begin
          a++;
          hit[k/8] = 1'b1;
        end
      end
    end
    b = $countones(hit);
    ctb = 8'(a); cto = 8'(b); cts = 8'(c);
  endtask

  task automatic run(input string tag, input int hold, input int poke);
    int lat, w0;
    w0 = wr_count;
    req = 1'b1;
    tick();
    check({tag, "_busy_on_accept"}, busy, 1);
    check({tag, "_done_dropped"}, done, 0);
    for (int i = 1; i < hold; i++) tick();
    req = 1'b0;
    lat = hold - 1;
    while (!done && lat < 100) begin
      if (poke != 0 && lat == poke) req = 1'b1;
      tick();
      req = 1'b0;
      lat++;
    end
    check({tag, "_latency"}, lat, 36);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_writes"}, wr_count - w0, 3);
  endtask

  task automatic expect3(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2);
    check({tag, "_ctb"}, mem[OUT], e0);
    check({tag, "_cto"}, mem[OUT+1], e1);
    check({tag, "_cts"}, mem[OUT+2], e2);
  endtask

  task automatic expect_model(input string tag);
    logic [7:0] e0, e1, e2;
    model(e0, e1, e2);
    expect3(tag, e0, e1, e2);
  endtask

  initial begin
    int w0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // Reset state
    #2;
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: alternating bits
    mem[PAT] = 8'hA8; fill(8'h55);
    run("s1", 1, 0);
    expect3("s1", 8'd64, 8'd32, 8'd126);
    expect_model("s1m");

    // 2: all-zero pattern on zeros, then a pattern that never matches
    mem[PAT] = 8'h07; fill(8'h00);
    run("s2a", 1, 0);
    expect3("s2a", 8'd128, 8'd32, 8'd252);
    mem[PAT] = 8'hA8;
    run("s2b", 1, 0);
    expect3("s2b", 8'd0, 8'd0, 8'd0);

    // 3: single byte-crossing hit
    mem[PAT] = 8'hE0; fill(8'h00); mem[0] = 8'h03; mem[1] = 8'h80;
    run("s3", 1, 0);
    expect3("s3", 8'd0, 8'd0, 8'd1);

    // 4: req mid-run ignored; req held three cycles starts one run
    mem[PAT] = 8'hA8; fill(8'h55);
    run("s4", 1, 9);
    expect3("s4", 8'd64, 8'd32, 8'd126);
    run("s4h", 3, 0);
    expect3("s4h", 8'd64, 8'd32, 8'd126);

    // 5: reset mid-SCAN aborts with no writes
    mem[OUT] = 8'hEE; mem[OUT+1] = 8'hEE; mem[OUT+2] = 8'hEE;
    mem[PAT] = 8'h07; fill(8'h00);
    w0 = wr_count;
    req = 1'b1; tick(); req = 1'b0;
    repeat (14) tick();
    rst_n = 1'b0;
    #1;
    check("s5_done", done, 0);
    check("s5_busy", busy, 0);
    check("s5_we", mem_we, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (40) tick();
    check("s5_idle_busy", busy, 0);
    check("s5_nowrite", wr_count - w0, 0);
    expect3("s5_keep", 8'hEE, 8'hEE, 8'hEE);
    run("s5r", 1, 0);
    expect3("s5r", 8'd128, 8'd32, 8'd252);

    // 6: back-to-back with a different pattern, req one cycle after done
    mem[PAT] = 8'h50; fill(8'h55); mem[5] = 8'hB3;
    run("s6a", 1, 0);
    expect_model("s6a");
    mem[PAT] = 8'h68;
    tick();
    check("s6_done_held", done, 1);
    run("s6b", 1, 0);
    expect_model("s6b");

    // Random pattern/message pairs
    for (int r = 0; r < 20; r++) begin
      mem[PAT] = 8'($urandom);
      for (int i = 0; i < 32; i++)
        mem[i] = (r % 2 == 0) ? 8'($urandom) : ((($urandom & 1) != 0) ? 8'hFF : 8'($urandom_range(0, 7)));
      run($sformatf("rnd%0d", r), 1, 0);
      expect_model($sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
